// File: rtl/im_boot_loader_pkg.sv
// Shared definitions for the boot loader: state encoding, default widths and
// the byte order used when packing stream bytes into instruction words.
package im_boot_loader_pkg;

  localparam int AW_DEF = 8;   // instruction-memory address width
  localparam int DW_DEF = 16;  // instruction width, always two bytes

  // The first data byte of each pair is the high half of the instruction.
  localparam bit HI_BYTE_FIRST = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_LEN   = 4'd1,
    ST_HI    = 4'd2,
    ST_LO    = 4'd3,
    ST_WRITE = 4'd4,
    ST_RST   = 4'd5,
    ST_START = 4'd6,
    ST_RUN   = 4'd7,
    ST_DONE  = 4'd8,
    ST_ERR   = 4'd9
  } state_e;

endpackage

// File: rtl/im_boot_loader_byte_pack16.sv
// Packs two consecutive stream bytes into one 16-bit instruction word.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_hi_en        : capture i_byte as the first byte of the pair
//   i_lo_en        : capture i_byte as the second byte and publish the word
//   i_byte         : stream byte
//   o_word         : packed word, changes only when the pair completes
//   o_word_valid   : one-cycle strobe in the cycle after the pair completes
module im_boot_loader_byte_pack16
  import im_boot_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_hi_en,
  input  logic        i_lo_en,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_word,
  output logic        o_word_valid
);

  logic [7:0]  r_first_byte;
  logic [15:0] r_word;
  logic        r_word_valid;

  // First byte is held aside so the published word never shows a half-updated value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_first_byte <= 8'h00;
      r_word       <= 16'h0000;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= i_lo_en;
      if (i_hi_en) begin
        r_first_byte <= i_byte;
      end
      if (i_lo_en) begin
        r_word <= HI_BYTE_FIRST ? {r_first_byte, i_byte} : {i_byte, r_first_byte};
      end
    end
  end

  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;

endmodule

// File: rtl/im_boot_loader.sv
// Boot and program-load sequencer for the 16-bit CPU subsystem.
// Receives a length byte followed by byte pairs, writes the packed words to
// instruction memory from address 0, then releases CPU reset, enables the CPU,
// pulses start and waits for halt.
// Ports:
//   clock, reset           : clock, async active-low reset
//   load_req               : start a load session (IDLE/DONE/ERR/RUN only)
//   rx_data/rx_valid/rx_ready : byte stream handshake
//   i_we/IM_addr/i_dataout : instruction-memory write port
//   cpu_reset/cpu_enable/cpu_start/cpu_halt : CPU control and status
//   busy/done/err/words_loaded : session status
module im_boot_loader
  import im_boot_loader_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 1024
)(
  input  logic          clock,
  input  logic          reset,
  input  logic          load_req,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          i_we,
  output logic [AW-1:0] IM_addr,
  output logic [DW-1:0] i_dataout,
  output logic          cpu_reset,
  output logic          cpu_enable,
  output logic          cpu_start,
  input  logic          cpu_halt,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   words_loaded
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  state_e        r_state;
  state_e        w_state_next;
  logic [AW-1:0] r_im_addr;
  logic [AW-1:0] r_last_addr;
  logic [AW:0]   r_words_loaded;
  logic [TW-1:0] r_gap_cnt;
  logic [3:0]    r_rst_cnt;
  logic          r_cpu_reset;
  logic          r_cpu_enable;
  logic          r_done;
  logic          r_err;
  logic          w_rx_ready;
  logic          w_busy;
  logic          w_cpu_start;
  logic          w_accept;
  logic          w_timeout;
  logic          w_enter_len;
  logic [15:0]   w_word;
  logic          w_word_valid;

  assign w_accept    = rx_valid && w_rx_ready;
  assign w_timeout   = w_rx_ready && !w_accept && (r_gap_cnt == TW'(TIMEOUT - 1));
  assign w_enter_len = (w_state_next == ST_LEN) && (r_state != ST_LEN);

  im_boot_loader_byte_pack16 u_pack (
    .i_clk        (clock),
    .i_rst_n      (reset),
    .i_hi_en      (w_accept && (r_state == ST_HI)),
    .i_lo_en      (w_accept && (r_state == ST_LO)),
    .i_byte       (rx_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; load_req is only honoured where a session may (re)start.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  w_state_next = load_req ? ST_LEN : ST_IDLE;
      ST_LEN:   w_state_next = w_accept ? ST_HI : (w_timeout ? ST_ERR : ST_LEN);
      ST_HI:    w_state_next = w_accept ? ST_LO : (w_timeout ? ST_ERR : ST_HI);
      ST_LO:    w_state_next = w_accept ? ST_WRITE : (w_timeout ? ST_ERR : ST_LO);
      ST_WRITE: w_state_next = (r_im_addr == r_last_addr) ? ST_RST : ST_HI;
      ST_RST:   w_state_next = (r_rst_cnt == 4'(RST_CYCLES - 1)) ? ST_START : ST_RST;
      ST_START: w_state_next = ST_RUN;
      // Abort wins over halt when both arrive together.
      ST_RUN:   w_state_next = load_req ? ST_LEN : (cpu_halt ? ST_DONE : ST_RUN);
      ST_DONE:  w_state_next = load_req ? ST_LEN : ST_DONE;
      ST_ERR:   w_state_next = load_req ? ST_LEN : ST_ERR;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    w_rx_ready  = 1'b0;
    w_busy      = 1'b0;
    w_cpu_start = 1'b0;
    case (r_state)
      ST_LEN, ST_HI, ST_LO: begin
        w_rx_ready = 1'b1;
        w_busy     = 1'b1;
      end
      ST_WRITE, ST_RST, ST_RUN: begin
        w_busy = 1'b1;
      end
      ST_START: begin
        w_busy      = 1'b1;
        w_cpu_start = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // Session datapath: address, length, word count and CPU control registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_im_addr      <= '0;
      r_last_addr    <= '0;
      r_words_loaded <= '0;
      r_cpu_reset    <= 1'b0;
      r_cpu_enable   <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
    end else if (w_enter_len) begin
      r_im_addr      <= '0;
      r_words_loaded <= '0;
      r_cpu_reset    <= 1'b0;
      r_cpu_enable   <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      case (r_state)
        ST_LEN, ST_HI, ST_LO: begin
          if (w_timeout) begin
            r_err        <= 1'b1;
            r_cpu_reset  <= 1'b0;
            r_cpu_enable <= 1'b0;
          end else if ((r_state == ST_LEN) && w_accept) begin
            // A length of 0 wraps to last_addr = all ones, i.e. a full memory.
            r_last_addr <= AW'(rx_data) - {{(AW-1){1'b0}}, 1'b1};
          end
        end
        ST_WRITE: begin
          r_words_loaded <= r_words_loaded + {{AW{1'b0}}, 1'b1};
          if (r_im_addr != r_last_addr) begin
            r_im_addr <= r_im_addr + {{(AW-1){1'b0}}, 1'b1};
          end
        end
        ST_RST: begin
          if (w_state_next == ST_START) begin
            r_cpu_reset  <= 1'b1;
            r_cpu_enable <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_state_next == ST_DONE) begin
            r_cpu_enable <= 1'b0;
            r_done       <= 1'b1;
          end
        end
        default: begin
          r_done <= r_done;
        end
      endcase
    end
  end

  // Gap counter: counts idle cycles while waiting for a byte.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_gap_cnt <= '0;
    end else if (!w_rx_ready || w_accept || w_enter_len) begin
      r_gap_cnt <= '0;
    end else begin
      r_gap_cnt <= r_gap_cnt + {{(TW-1){1'b0}}, 1'b1};
    end
  end

  // Counts cycles spent holding the CPU in reset after the last write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rst_cnt <= 4'd0;
    end else if (r_state == ST_RST) begin
      r_rst_cnt <= r_rst_cnt + 4'd1;
    end else begin
      r_rst_cnt <= 4'd0;
    end
  end

  assign rx_ready     = w_rx_ready;
  assign busy         = w_busy;
  assign cpu_start    = w_cpu_start;
  assign i_we         = w_word_valid;
  assign IM_addr      = r_im_addr;
  assign i_dataout    = DW'(w_word);
  assign cpu_reset    = r_cpu_reset;
  assign cpu_enable   = r_cpu_enable;
  assign done         = r_done;
  assign err          = r_err;
  assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_im_boot_loader.sv
// Self-checking bench for im_boot_loader: expected IM writes go into a
// scoreboard queue as words are streamed; a monitor pops and compares on i_we.
module tb_im_boot_loader;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       load_req = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic       i_we;
  logic [7:0] IM_addr;
  logic [15:0] i_dataout;
  logic       cpu_reset;
  logic       cpu_enable;
  logic       cpu_start;
  logic       cpu_halt = 1'b0;
  logic       busy;
  logic       done;
  logic       err;
  logic [8:0] words_loaded;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];

  always #5 clock = ~clock;

  im_boot_loader dut (
    .clock(clock), .reset(reset), .load_req(load_req),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .i_we(i_we), .IM_addr(IM_addr), .i_dataout(i_dataout),
    .cpu_reset(cpu_reset), .cpu_enable(cpu_enable), .cpu_start(cpu_start),
    .cpu_halt(cpu_halt), .busy(busy), .done(done), .err(err),
    .words_loaded(words_loaded)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every IM write must match the oldest expected write.
  always @(negedge clock) begin
    if (reset && i_we) begin
      logic [23:0] item;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", IM_addr, i_dataout);
      end else begin
        item = exp_q.pop_front();
        if ({IM_addr, i_dataout} !== item) begin
          errors++;
          $display("FAIL im_write: got addr %0h data %0h expected addr %0h data %0h",
                   IM_addr, i_dataout, item[23:16], item[15:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clock);
    while (!rx_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!rx_ready) chk("rx_ready_wait", 0, 1);
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] addr, input logic [15:0] w);
    exp_q.push_back({addr, w});
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  // Called right after the last LO byte was accepted (DUT now in WRITE).
  task automatic check_boot(input int nwords);
    tick();
    chk("rst1_cpu_reset", 32'(cpu_reset), 0);
    chk("words_loaded", 32'(words_loaded), 32'(nwords));
    tick();
    chk("rst2_cpu_reset", 32'(cpu_reset), 0);
    chk("rst2_cpu_start", 32'(cpu_start), 0);
    tick();
    chk("start_cpu_reset", 32'(cpu_reset), 1);
    chk("start_cpu_enable", 32'(cpu_enable), 1);
    chk("start_cpu_start", 32'(cpu_start), 1);
    tick();
    chk("run_cpu_start", 32'(cpu_start), 0);
    chk("run_busy", 32'(busy), 1);
  endtask

  task automatic halt_cpu();
    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
    chk("halt_done", 32'(done), 1);
    chk("halt_cpu_enable", 32'(cpu_enable), 0);
    chk("halt_busy", 32'(busy), 0);
    chk("halt_cpu_reset", 32'(cpu_reset), 1);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_rx_ready", 32'(rx_ready), 0);
    chk("rst_i_we", 32'(i_we), 0);
    chk("rst_addr", 32'(IM_addr), 0);
    chk("rst_data", 32'(i_dataout), 0);
    chk("rst_cpu_reset", 32'(cpu_reset), 0);
    chk("rst_cpu_enable", 32'(cpu_enable), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done_err", 32'({done, err, cpu_start}), 0);
    chk("rst_words", 32'(words_loaded), 0);
    reset = 1'b1;
    tick();

    // Three-word load with a continuous stream
    pulse_load();
    chk("len_busy", 32'(busy), 1);
    send_byte(8'h03);
    send_word(8'h00, 16'hAABB);
    send_word(8'h01, 16'h1234);
    send_word(8'h02, 16'h5678);
    check_boot(3);
    halt_cpu();

    // Length 0 means a full 256-word image
    pulse_load();
    chk("reload_done_clr", 32'(done), 0);
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      send_word(8'(i), {8'(i), 8'(8'd255 - 8'(i))});
    end
    chk("full_last_addr", 32'(IM_addr), 32'h0FF);
    check_boot(256);
    halt_cpu();

    // 1000-cycle gap between HI and LO is tolerated
    pulse_load();
    send_byte(8'h02);
    exp_q.push_back({8'h00, 16'hC0DE});
    send_byte(8'hC0);
    repeat (1000) tick();
    chk("gap_err", 32'(err), 0);
    send_byte(8'hDE);
    send_word(8'h01, 16'hBEEF);
    check_boot(2);
    halt_cpu();

    // 1024 idle cycles times out
    pulse_load();
    send_byte(8'h02);
    send_word(8'h00, 16'h0F0F);
    send_byte(8'h77);
    repeat (1023) tick();
    chk("to_edge_err", 32'(err), 0);
    chk("to_edge_ready", 32'(rx_ready), 1);
    tick();
    chk("to_err", 32'(err), 1);
    chk("to_cpu_reset", 32'(cpu_reset), 0);
    chk("to_busy", 32'(busy), 0);
    chk("to_rx_ready", 32'(rx_ready), 0);
    chk("to_words", 32'(words_loaded), 1);
    repeat (5) tick();

    // load_req clears err and restarts at address 0
    pulse_load();
    chk("clr_err", 32'(err), 0);
    chk("clr_addr", 32'(IM_addr), 0);
    chk("clr_words", 32'(words_loaded), 0);
    send_byte(8'h01);
    send_word(8'h00, 16'h1357);
    check_boot(1);

    // Abort in RUN with halt in the same cycle: load_req wins
    load_req = 1'b1;
    cpu_halt = 1'b1;
    tick();
    load_req = 1'b0;
    cpu_halt = 1'b0;
    chk("abort_cpu_reset", 32'(cpu_reset), 0);
    chk("abort_cpu_enable", 32'(cpu_enable), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_busy", 32'(busy), 1);

    // load_req during HI is ignored
    send_byte(8'h02);
    pulse_load();
    chk("hi_req_addr", 32'(IM_addr), 0);
    send_word(8'h00, 16'h2468);
    send_word(8'h01, 16'hACE0);
    check_boot(2);

    // Async reset while in WRITE
    pulse_load();
    send_byte(8'h01);
    send_byte(8'h99);
    send_byte(8'h88);
    #1;
    reset = 1'b0;
    #1;
    chk("ar_i_we", 32'(i_we), 0);
    chk("ar_cpu_reset", 32'(cpu_reset), 0);
    chk("ar_busy", 32'(busy), 0);
    tick();
    reset = 1'b1;
    tick();
    chk("ar_rx_ready", 32'(rx_ready), 0);
    chk("ar_idle_busy", 32'(busy), 0);
    chk("ar_addr", 32'(IM_addr), 0);

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/im_boot_loader.md
Name: im_boot_loader

Overview:
- Boot and program-load sequencer for the 16-bit CPU subsystem.
- Receives a program as a byte stream over a valid/ready handshake and packs byte pairs into 16-bit instruction words.
- Drives the instruction-memory write port (i_we / IM_addr / i_dataout) sequentially from address 0.
- Then sequences CPU reset release, enable and a one-cycle start pulse, and monitors halt.

Parameters:
- AW, 8, IM address width.
- DW, 16, instruction width; fixed at 2 bytes per word.
- RST_CYCLES, 2, cycles cpu_reset is held low after the last write (1..15).
- TIMEOUT, 1024, maximum idle cycles between accepted bytes during a load.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_req  in  1  one-cycle request to begin a load session.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader can accept a byte.
- i_we  out  1  IM write enable.
- IM_addr  out  AW  IM write address.
- i_dataout  out  DW  IM write data.
- cpu_reset  out  1  active-low reset to the CPU core.
- cpu_enable  out  1  CPU enable.
- cpu_start  out  1  one-cycle CPU start pulse.
- cpu_halt  in  1  CPU has executed HALT (level).
- busy  out  1  a load or run is in progress.
- done  out  1  program ran to HALT (sticky until next load_req).
- err  out  1  load aborted by timeout (sticky until next load_req).
- words_loaded  out  AW+1  count of words written in the current session.

Behaviour:
- Reset (async, reset=0): state IDLE.
  - All outputs 0, including cpu_reset=0, so the CPU is held in reset.
  - Counters and IM_addr are 0.
- Handshake: a byte is accepted when rx_valid && rx_ready. rx_ready=1 only in LEN, HI and LO. Accepted bytes are registered; there is no combinational path from rx_valid to any output.
- States:
  - IDLE: wait. load_req -> LEN. Entering LEN clears done, err and words_loaded, sets IM_addr=0, cpu_reset=0, cpu_enable=0.
  - LEN: accept byte N. Word count = N, with N=0 meaning 2^AW (256). Store last_addr = N-1 (mod 2^AW). -> HI.
  - HI: accept byte; it is data[15:8]. -> LO.
  - LO: accept byte; it is data[7:0]. -> WRITE.
  - WRITE: exactly one cycle with i_we=1, IM_addr and i_dataout stable. words_loaded increments at the end of the cycle.
    - If IM_addr==last_addr -> RST.
    - Otherwise IM_addr increments at the end of the cycle -> HI.
  - RST: cpu_reset=0 for RST_CYCLES cycles. On exit, cpu_reset=1 and cpu_enable=1 -> START.
  - START: cpu_start=1 for exactly one cycle -> RUN.
  - RUN: wait for cpu_halt=1.
    - On halt: cpu_enable=0, done=1 -> DONE.
    - cpu_reset stays 1 so CPU state remains inspectable.
  - DONE: hold. load_req -> LEN.
  - ERR: cpu_reset=0, cpu_enable=0, err=1. load_req -> LEN.
- Timeout:
  - A gap counter runs in LEN, HI and LO and clears on every accepted byte and on entering LEN.
  - When the counter reaches TIMEOUT-1 with no byte accepted that cycle -> ERR.
  - IM contents already written are left as-is.
- busy = 1 in LEN, HI, LO, WRITE, RST, START and RUN.
- i_we is 0 in every state except WRITE; IM_addr and i_dataout hold their last values.
- load_req handling:
  - Honoured in IDLE, DONE, ERR and RUN. In RUN it aborts the program: cpu_reset=0, cpu_enable=0 -> LEN.
  - Ignored in LEN, HI, LO, WRITE, RST and START.
  - load_req and cpu_halt in the same RUN cycle: load_req wins; done stays 0.
- Wrap-around: N=0 writes all 256 addresses 0..255. IM_addr wraps back to 0 only via the next LEN entry, never by incrementing.
- Reset mid-operation: asynchronous return to IDLE with the CPU held in reset. Partial IM contents are undefined from the CPU's point of view.

Decomposition:
- Shared package / config include: state encoding constants (IDLE, LEN, HI, LO, WRITE, RST, START, RUN, DONE, ERR), AW/DW defaults, and a byte-order constant (high byte first).
- Sub-module byte_pack16: HI/LO byte capture register producing the 16-bit word and a word_valid strobe.
- The gap-timeout counter stays inline in the loader.

Test Plan:
- Load of 3 words. Stream 03,AA,BB,12,34,56,78 with rx_valid continuous:
  - i_we pulses at IM_addr 0,1,2 with data AABB, 1234, 5678; words_loaded=3.
  - cpu_reset rises 2 cycles after the last write.
  - cpu_start pulses one cycle later with cpu_enable=1.
  - cpu_halt=1 -> done=1, cpu_enable=0, busy=0.
- Length 0: byte 00 followed by 512 data bytes -> 256 writes, last at IM_addr FF; words_loaded=256; then the RST/START sequence.
- Gaps and timeout:
  - Drop rx_valid for 1000 cycles between HI and LO -> load completes normally.
  - Gap of 1024 cycles -> err=1, cpu_reset=0, busy=0, no further i_we.
  - load_req afterwards clears err and restarts at IM_addr 0.
- Abort in RUN: load_req while running -> cpu_reset=0, cpu_enable=0 next cycle; new load writes from addr 0.
  - With load_req and cpu_halt asserted in the same cycle: done stays 0.
- Async reset asserted mid-WRITE -> outputs immediately 0 (cpu_reset=0, i_we=0); after release, state is IDLE and rx_ready=0.
- load_req pulsed during HI -> ignored; the byte sequence and write addresses are unchanged.
